video_line_taps: RTL and testbench
==================================

# video_line_taps

Parametrised multi-line tap generator for the video shift path: buffers the last TAPS lines of a pixel stream in internal dual-port RAM and presents, each valid cycle, the current pixel plus the same-column pixel from each of the previous TAPS lines. It is the generalised successor of the single shift RAM, adding internal column/line counters, frame restart, programmable line length and per-tap fill status. It feeds 2D window and filter kernels.

## Interface
- DSIZE, 24, pixel width in bits
- ASIZE, 10, column address width; max line length 2^ASIZE-1
- TAPS, 3, number of delayed lines, legal 1..8
- clock  in  1  sole clock, all logic rising-edge
- rst  in  1  asynchronous, active-high reset
- sof  in  1  start-of-frame pulse, one cycle
- line_len  in  ASIZE  active pixels per line, sampled on sof
- in_vld  in  1  input pixel valid
- in_data  in  DSIZE  input pixel
- out_vld  out  1  output valid
- out_data  out  DSIZE  current pixel, delayed
- out_taps  out  TAPS*DSIZE  tap k at bits [(k+1)*DSIZE-1 : k*DSIZE], k+1 lines old
- out_taps_ok  out  TAPS  bit k set when tap k holds data from the current frame

## Operation
- One RAM per tap, depth 2^ASIZE, width DSIZE, registered read.
- Column counter col: increments per in_vld; at col == len_q-1 wraps to 0 and line counter lines_seen increments, saturating at TAPS.
- len_q: latched from line_len on sof; values 0 and 1 clamp to 2 (avoids same-address read/write). Reset value 2.
- Cycle with in_vld: all RAMs read address col. Next cycle: RAM 0 writes the delayed in_data, RAM k (k>0) writes RAM k-1's read data, all at delayed col. Chain shifts one line per tap.
- in_vld low: counters hold, no RAM writes, out_vld low, data outputs hold.
- sof: col and lines_seen clear to 0, out_taps_ok clears. If in_vld is high in the same cycle, that pixel is col 0 of the new frame. RAM contents are not cleared.
- out_taps_ok[k] = (lines_seen > k), registered alongside out_vld.
- Pixels arriving before the first sof are processed with len_q = 2 (reset value).

## Timing
- Latency: 1 cycle from in_vld/in_data to out_vld/out_data/out_taps.
- Throughput: one pixel per cycle, no back-pressure.
- Reset values: out_vld 0, out_data 0, out_taps 0, out_taps_ok 0, col 0, lines_seen 0, len_q 2.
- rst mid-line: counters and outputs return to reset values immediately; pending RAM write in that cycle is dropped.
- sof and line wrap in the same cycle: sof wins, lines_seen = 0.
- line_len change without sof: ignored until next sof.

## Configuration
- Macro VLT_EDGE_REPLICATE_EN.
- Defined: any tap whose out_taps_ok bit is 0 outputs the nearest newer valid data instead (tap 0 copies out_data; tap k copies the already-substituted tap k-1), giving top-edge replication at frame start.
- Undefined: taps always output raw RAM data; consumers must qualify with out_taps_ok.

## Test plan
- rst asserted mid-stream -> same cycle out_vld=0, out_taps=0, out_taps_ok=0; after release with sof, counters start at col 0.
- TAPS=3, line_len=4, sof then 5 dense lines, pixel = row*16+col -> at row 3 col 2 output: out_data=0x32, taps 0x22/0x12/0x02, out_taps_ok=3'b111.
- Same stream with in_vld low every other cycle -> identical output sequence on out_vld cycles, no extra writes.
- sof asserted at row 2 col 1 with in_vld -> that pixel is col 0, out_taps_ok=3'b000 next cycle, becomes 3'b001 after 4 more pixels.
- line_len=1 on sof -> behaves as 2: tap 0 at pixel 2 equals pixel 0.
- VLT_EDGE_REPLICATE_EN defined, line_len=4, pixel = row*16+col -> row 0 col 1: all taps=0x01; row 1 col 1: tap0=0x01, tap1=tap2=0x01; row 2 col 3: tap0=0x13, tap1=0x03, tap2=0x03.

Source files
------------

// File: rtl/video_line_taps_if.sv
// Video line-tap stream interface: pixel stream in, current pixel plus same-column line taps out.
interface video_line_taps_if #(
  parameter int unsigned DSIZE = 24,
  parameter int unsigned ASIZE = 10,
  parameter int unsigned TAPS  = 3
) ();
  logic                    sof;
  logic [ASIZE-1:0]        line_len;
  logic                    in_vld;
  logic [DSIZE-1:0]        in_data;
  logic                    out_vld;
  logic [DSIZE-1:0]        out_data;
  logic [TAPS*DSIZE-1:0]   out_taps;
  logic [TAPS-1:0]         out_taps_ok;

  modport master (
    output sof, line_len, in_vld, in_data,
    input  out_vld, out_data, out_taps, out_taps_ok
  );

  modport slave (
    input  sof, line_len, in_vld, in_data,
    output out_vld, out_data, out_taps, out_taps_ok
  );
endinterface

// File: rtl/video_line_taps.sv
// Multi-line tap generator: one RAM per tap, chained so each RAM holds one line older than the previous.
// Optional VLT_EDGE_REPLICATE_EN: taps not yet filled in the current frame replicate the nearest newer valid data.
module video_line_taps #(
  parameter int unsigned DSIZE = 24,
  parameter int unsigned ASIZE = 10,
  parameter int unsigned TAPS  = 3
) (
  input logic              clock,
  input logic              rst,
  video_line_taps_if.slave vid
);
  localparam int unsigned DEPTH = 1 << ASIZE;
  localparam int unsigned LW    = $clog2(TAPS + 1);

  logic [ASIZE-1:0]            r_len_q;
  logic [ASIZE-1:0]            r_col;
  logic [LW-1:0]               r_lines;
  logic [DSIZE-1:0]            r_mem [TAPS][DEPTH];
  logic [DSIZE-1:0]            r_rd  [TAPS];
  logic                        r_wr_en;
  logic [ASIZE-1:0]            r_wr_addr;
  logic [DSIZE-1:0]            r_wr_data;
  logic                        r_out_vld;
  logic [DSIZE-1:0]            r_out_data;
  logic [TAPS-1:0][DSIZE-1:0]  r_out_taps;
  logic [TAPS-1:0]             r_out_ok;

  logic [ASIZE-1:0]            w_len_clamp;
  logic [ASIZE-1:0]            w_len_eff;
  logic [ASIZE-1:0]            w_col_eff;
  logic [LW-1:0]               w_lines_eff;
  logic                        w_wrap;
  logic [TAPS-1:0]             w_ok_nxt;
  logic [TAPS-1:0][DSIZE-1:0]  w_taps_nxt;

  // sof restarts the frame in the same cycle, so a coincident pixel is column 0
  always_comb begin
    w_len_clamp = (vid.line_len < ASIZE'(2)) ? ASIZE'(2) : vid.line_len;
    w_len_eff   = vid.sof ? w_len_clamp : r_len_q;
    w_col_eff   = vid.sof ? '0 : r_col;
    w_lines_eff = vid.sof ? '0 : r_lines;
    w_wrap      = (w_col_eff == (w_len_eff - ASIZE'(1)));
  end

  // Tap data for the output register, with optional top-edge replication
  always_comb begin
    w_ok_nxt   = '0;
    w_taps_nxt = '0;
    for (int k = 0; k < TAPS; k++) begin
      w_ok_nxt[k]   = (w_lines_eff > LW'(k));
      w_taps_nxt[k] = r_mem[k][w_col_eff];
    end
`ifdef VLT_EDGE_REPLICATE_EN
    if (!w_ok_nxt[0]) w_taps_nxt[0] = vid.in_data;
    for (int k = 1; k < TAPS; k++) begin
      if (!w_ok_nxt[k]) w_taps_nxt[k] = w_taps_nxt[k-1];
    end
`endif
  end

  // Line RAMs: registered read on the pixel cycle, chained write one cycle later
  always_ff @(posedge clock) begin
    for (int k = 0; k < TAPS; k++) begin
      if (vid.in_vld) r_rd[k] <= r_mem[k][w_col_eff];
    end
    if (r_wr_en) r_mem[0][r_wr_addr] <= r_wr_data;
    for (int k = 1; k < TAPS; k++) begin
      if (r_wr_en) r_mem[k][r_wr_addr] <= r_rd[k-1];
    end
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_len_q    <= ASIZE'(2);
      r_col      <= '0;
      r_lines    <= '0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_out_vld  <= 1'b0;
      r_out_data <= '0;
      r_out_taps <= '0;
      r_out_ok   <= '0;
    end else begin
      if (vid.sof) r_len_q <= w_len_clamp;
      r_wr_en   <= vid.in_vld;
      r_out_vld <= vid.in_vld;
      if (vid.in_vld) begin
        r_wr_addr  <= w_col_eff;
        r_wr_data  <= vid.in_data;
        r_col      <= w_wrap ? '0 : (w_col_eff + ASIZE'(1));
        r_lines    <= (w_wrap && (w_lines_eff != LW'(TAPS))) ? (w_lines_eff + LW'(1)) : w_lines_eff;
        r_out_data <= vid.in_data;
        r_out_taps <= w_taps_nxt;
        r_out_ok   <= w_ok_nxt;
      end else if (vid.sof) begin
        r_col    <= '0;
        r_lines  <= '0;
        r_out_ok <= '0;
      end
    end
  end

  assign vid.out_vld     = r_out_vld;
  assign vid.out_data    = r_out_data;
  assign vid.out_taps    = r_out_taps;
  assign vid.out_taps_ok = r_out_ok;

endmodule

// File: tb/tb_video_line_taps.sv
// Self-checking bench for video_line_taps: line-history model feeding a scoreboard queue, plus fixed-value spot checks.
module tb_video_line_taps;
  localparam int unsigned DSIZE = 24;
  localparam int unsigned ASIZE = 10;
  localparam int unsigned TAPS  = 3;
  localparam int unsigned DEPTH = 1 << ASIZE;

  typedef logic [DSIZE-1:0] pix_t;
  typedef logic [TAPS-1:0][DSIZE-1:0] taps_t;
  typedef struct packed {
    pix_t            data;
    taps_t           taps;
    logic [TAPS-1:0] ok;
    logic [TAPS-1:0] known;
  } exp_t;

  logic clock = 1'b0;
  logic rst   = 1'b1;

  video_line_taps_if #(.DSIZE(DSIZE), .ASIZE(ASIZE), .TAPS(TAPS)) vid ();

  video_line_taps #(.DSIZE(DSIZE), .ASIZE(ASIZE), .TAPS(TAPS)) dut (
    .clock (clock),
    .rst   (rst),
    .vid   (vid)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  exp_t sb_q[$];

  // Per-column history of the last TAPS pixels seen at that column
  pix_t        m_hist  [DEPTH][TAPS];
  bit          m_known [DEPTH][TAPS];
  int unsigned m_len   = 2;
  int unsigned m_col   = 0;
  int unsigned m_lines = 0;

  task automatic model_reset();
    m_len = 2; m_col = 0; m_lines = 0;
    for (int c = 0; c < DEPTH; c++)
      for (int k = 0; k < TAPS; k++) m_known[c][k] = 1'b0;
    sb_q.delete();
  endtask

  task automatic model_step(input bit s, input bit v, input pix_t d, input logic [ASIZE-1:0] len);
    exp_t e;
    if (s) begin
      m_len = (int'(len) < 2) ? 2 : int'(len);
      m_col = 0; m_lines = 0;
    end
    if (v) begin
      e.data = d;
      for (int k = 0; k < TAPS; k++) begin
        e.ok[k]    = (m_lines > k);
        e.known[k] = m_known[m_col][k];
        e.taps[k]  = m_hist[m_col][k];
      end
`ifdef VLT_EDGE_REPLICATE_EN
      if (!e.ok[0]) begin e.taps[0] = d; e.known[0] = 1'b1; end
      for (int k = 1; k < TAPS; k++)
        if (!e.ok[k]) begin e.taps[k] = e.taps[k-1]; e.known[k] = e.known[k-1]; end
`endif
      for (int k = 0; k < TAPS; k++) if (!e.known[k]) e.taps[k] = '0;
      sb_q.push_back(e);
      for (int k = TAPS - 1; k > 0; k--) begin
        m_hist[m_col][k]  = m_hist[m_col][k-1];
        m_known[m_col][k] = m_known[m_col][k-1];
      end
      m_hist[m_col][0] = d; m_known[m_col][0] = 1'b1;
      if (m_col == m_len - 1) begin
        m_col = 0;
        if (m_lines < TAPS) m_lines++;
      end else m_col++;
    end
  endtask

  function automatic exp_t observe(input exp_t e);
    exp_t a;
    a.data  = vid.out_data;
    a.ok    = vid.out_taps_ok;
    a.known = e.known;
    for (int k = 0; k < TAPS; k++) a.taps[k] = e.known[k] ? vid.out_taps[k*DSIZE +: DSIZE] : '0;
    return a;
  endfunction

  // Drive one cycle, then sample #1 after the edge that registered it
  task automatic cycle(input bit s, input bit v, input pix_t d, input logic [ASIZE-1:0] len);
    vid.sof = s; vid.in_vld = v; vid.in_data = d; vid.line_len = len;
    @(posedge clock); #1;
    model_step(s, v, d, len);
    vid.sof = 1'b0; vid.in_vld = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e, a;
    rst = 1'b1; vid.sof = 1'b0; vid.in_vld = 1'b0; vid.in_data = '0; vid.line_len = ASIZE'(4);
    repeat (3) @(posedge clock);
    #1;
    n_checks++;
    if ({vid.out_vld, vid.out_data, vid.out_taps, vid.out_taps_ok} !== '0) begin
      n_fail++;
      $display("FAIL reset_values: got vld=%b data=%h taps=%h ok=%b, expected all zero",
               vid.out_vld, vid.out_data, vid.out_taps, vid.out_taps_ok);
    end
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, pix_t'(8'hA0 + i), ASIZE'(4));
      e = sb_q.pop_front(); a = observe(e);
      n_checks++;
      if (vid.out_vld !== 1'b1 || a !== e) begin
        n_fail++; $display("FAIL pre_sof %0d: vld=%b got %h expected %h", i, vid.out_vld, a, e);
      end
    end
    n_checks++;
    if (vid.out_taps[DSIZE-1:0] !== pix_t'(8'hA0) || vid.out_taps_ok !== 3'b001) begin
      n_fail++;
      $display("FAIL pre_sof_len2: tap0=%h ok=%b, expected tap0=a0 ok=001", vid.out_taps[DSIZE-1:0], vid.out_taps_ok);
    end
  endtask

  task automatic test_stream(input string name, input bit gaps);
    exp_t e, a;
    taps_t t_exp;
    cycle(1'b0, 1'b0, '0, ASIZE'(4));
    void'(sb_q.size());
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 4; c++) begin
        cycle((r == 0 && c == 0), 1'b1, pix_t'(r*16 + c), ASIZE'(4));
        e = sb_q.pop_front(); a = observe(e);
        n_checks++;
        if (vid.out_vld !== 1'b1 || a !== e) begin
          n_fail++; $display("FAIL %s r%0d c%0d: vld=%b got %h expected %h", name, r, c, vid.out_vld, a, e);
        end
        if (r == 3 && c == 2) begin
          t_exp = {pix_t'(8'h02), pix_t'(8'h12), pix_t'(8'h22)};
          n_checks++;
          if (vid.out_data !== pix_t'(8'h32) || vid.out_taps !== t_exp || vid.out_taps_ok !== 3'b111) begin
            n_fail++;
            $display("FAIL %s_r3c2: data=%h taps=%h ok=%b, expected 32 %h 111", name, vid.out_data, vid.out_taps, vid.out_taps_ok, t_exp);
          end
        end
`ifdef VLT_EDGE_REPLICATE_EN
        if ((r == 0 || r == 1) && c == 1) begin
          t_exp = {pix_t'(8'h01), pix_t'(8'h01), pix_t'(8'h01)};
          n_checks++;
          if (vid.out_taps !== t_exp) begin
            n_fail++; $display("FAIL %s_repl_r%0dc1: taps=%h expected %h", name, r, vid.out_taps, t_exp);
          end
        end
        if (r == 2 && c == 3) begin
          t_exp = {pix_t'(8'h03), pix_t'(8'h03), pix_t'(8'h13)};
          n_checks++;
          if (vid.out_taps !== t_exp) begin
            n_fail++; $display("FAIL %s_repl_r2c3: taps=%h expected %h", name, vid.out_taps, t_exp);
          end
        end
`endif
        if (gaps) begin
          cycle(1'b0, 1'b0, pix_t'(24'hFFFFFF), ASIZE'(4));
          n_checks++;
          if (vid.out_vld !== 1'b0 || vid.out_data !== pix_t'(r*16 + c)) begin
            n_fail++; $display("FAIL %s_gap r%0d c%0d: vld=%b data=%h, expected vld=0 data=%h", name, r, c, vid.out_vld, vid.out_data, pix_t'(r*16 + c));
          end
        end
      end
    end
  endtask

  task automatic test_sof_midline();
    exp_t e, a;
    cycle(1'b0, 1'b0, '0, ASIZE'(4));
    for (int i = 0; i < 14; i++) begin
      bit s, v;
      pix_t d;
      s = (i == 0) || (i == 10);
      v = (i != 9);
      d = (i < 10) ? pix_t'((i / 4) * 16 + (i % 4)) : pix_t'(8'h21 + (i - 10));
      cycle(s, v, d, ASIZE'(4));
      if (v) begin e = sb_q.pop_front(); a = observe(e); end else begin e = '0; a = '0; end
      n_checks++;
      if (vid.out_vld !== v || a !== e) begin
        n_fail++; $display("FAIL sof_midline %0d: vld=%b got %h expected vld=%b %h", i, vid.out_vld, a, v, e);
      end
      if (i == 10 || i == 13) begin
        n_checks++;
        if (vid.out_taps_ok !== 3'(0)) begin
          n_fail++; $display("FAIL sof_midline_ok_clear %0d: ok=%b expected 000", i, vid.out_taps_ok);
        end
      end
    end
    cycle(1'b0, 1'b1, pix_t'(8'h30), ASIZE'(4));
    e = sb_q.pop_front(); a = observe(e);
    n_checks++;
    if (vid.out_taps_ok !== 3'b001 || a !== e) begin
      n_fail++; $display("FAIL sof_midline_ok_fill: ok=%b got %h expected ok=001 %h", vid.out_taps_ok, a, e);
    end
  endtask

  task automatic test_len_clamp();
    exp_t e, a;
    cycle(1'b0, 1'b0, '0, ASIZE'(1));
    for (int i = 0; i < 4; i++) begin
      cycle((i == 0), 1'b1, pix_t'(8'hB0 + i), (i < 2) ? ASIZE'(1) : ASIZE'(7));
      e = sb_q.pop_front(); a = observe(e);
      n_checks++;
      if (vid.out_vld !== 1'b1 || a !== e) begin
        n_fail++; $display("FAIL len_clamp %0d: vld=%b got %h expected %h", i, vid.out_vld, a, e);
      end
      if (i >= 2) begin
        n_checks++;
        if (vid.out_taps[DSIZE-1:0] !== pix_t'(8'hB0 + i - 2)) begin
          n_fail++; $display("FAIL len_clamp_tap0 %0d: tap0=%h expected %h", i, vid.out_taps[DSIZE-1:0], pix_t'(8'hB0 + i - 2));
        end
      end
    end
  endtask

  task automatic test_reset_midstream();
    exp_t e, a;
    cycle(1'b0, 1'b0, '0, ASIZE'(4));
    for (int i = 0; i < 6; i++) begin
      cycle((i == 0), 1'b1, pix_t'(8'hC0 + i), ASIZE'(4));
      void'(sb_q.pop_front());
    end
    vid.in_vld = 1'b1; vid.in_data = pix_t'(8'hC6);
    @(posedge clock); #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({vid.out_vld, vid.out_data, vid.out_taps, vid.out_taps_ok} !== '0) begin
      n_fail++;
      $display("FAIL reset_midstream: got vld=%b data=%h taps=%h ok=%b, expected all zero",
               vid.out_vld, vid.out_data, vid.out_taps, vid.out_taps_ok);
    end
    vid.in_vld = 1'b0;
    model_reset();
    repeat (2) @(posedge clock);
    #1; rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cycle((i == 0), 1'b1, pix_t'(8'hD0 + i), ASIZE'(3));
      e = sb_q.pop_front(); a = observe(e);
      n_checks++;
      if (vid.out_vld !== 1'b1 || a !== e) begin
        n_fail++; $display("FAIL post_reset %0d: vld=%b got %h expected %h", i, vid.out_vld, a, e);
      end
      if (i == 3) begin
        n_checks++;
        if (vid.out_taps[DSIZE-1:0] !== pix_t'(8'hD0) || vid.out_taps_ok !== 3'b001) begin
          n_fail++; $display("FAIL post_reset_col0: tap0=%h ok=%b expected d0 001", vid.out_taps[DSIZE-1:0], vid.out_taps_ok);
        end
      end
    end
  endtask

  task automatic test_random();
    exp_t e, a;
    bit prev_idle = 1'b0;
    for (int i = 0; i < 400; i++) begin
      bit s, v;
      s = prev_idle && ($urandom_range(0, 24) == 0);
      v = ($urandom_range(0, 3) != 0);
      cycle(s, v, pix_t'($urandom), ASIZE'($urandom_range(0, 6)));
      prev_idle = !v;
      if (v) begin e = sb_q.pop_front(); a = observe(e); end else begin e = '0; a = '0; end
      n_checks++;
      if (vid.out_vld !== v || a !== e) begin
        n_fail++; $display("FAIL random %0d: vld=%b got %h expected vld=%b %h", i, vid.out_vld, a, v, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream("dense", 1'b0);
    test_stream("gaps", 1'b1);
    test_sof_midline();
    test_len_clamp();
    test_reset_midstream();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
